// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and width default for the PISO serializer
package piso_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: saturating bit index 0..WIDTH-1 with synchronous clear
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // clear wins over inc; the index never wraps past WIDTH-1
    always_comb begin
        last    = count_q == CW'(WIDTH - 1);
        count_d = clear ? '0 : (inc && !last) ? count_q + 1'b1 : count_q;
    end

    // index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: loads a parallel word and streams it out one bit per enabled cycle
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             msb_first,
    input  logic             shift_en,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done
);

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          shreg_q, shreg_d;
    logic                      msb_q, msb_d;
    logic                      sout_q, sout_d;
    logic                      frame_start_q, frame_start_d;
    logic                      in_shift, accept, advance;
    logic                      cnt_clear, cnt_inc, last;
    logic [$clog2(WIDTH)-1:0]  count;

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (count),
        .last  (last)
    );

    // the shift register keeps the bit on sout at its outgoing end (MSB or LSB)
    // and moves the next one there on each enabled advance
    always_comb begin
        in_shift      = state_q == SHIFT;
        load_ready    = !rst && (!in_shift || (last && shift_en));
        accept        = load_valid && load_ready;
        advance       = in_shift && shift_en;
        cnt_clear     = accept || (advance && last);
        cnt_inc       = advance && !last;
        state_d       = state_q;
        shreg_d       = shreg_q;
        msb_d         = msb_q;
        sout_d        = sout_q;
        frame_start_d = frame_start_q;
        if (accept) begin
            state_d       = SHIFT;
            shreg_d       = load_data;
            msb_d         = msb_first;
            sout_d        = msb_first ? load_data[WIDTH-1] : load_data[0];
            frame_start_d = 1'b1;
        end else if (advance && last) begin
            state_d       = IDLE;
            shreg_d       = '0;
            sout_d        = 1'b0;
            frame_start_d = 1'b0;
        end else if (advance) begin
            shreg_d       = msb_q ? shreg_q << 1 : shreg_q >> 1;
            sout_d        = msb_q ? shreg_q[WIDTH-2] : shreg_q[1];
            frame_start_d = 1'b0;
        end
    end

    // FSM and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            msb_q         <= 1'b0;
            sout_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            msb_q         <= msb_d;
            sout_q        <= sout_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = in_shift;
    assign frame_start = frame_start_q;
    assign done        = in_shift && last;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: random and directed checks against a frame-level reference model
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         msb_first = 1'b0;
    logic         shift_en = 1'b1;
    logic         load_ready, sout, sout_valid, frame_start, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic         m_active = 1'b0;
    int           m_pos = 0;
    logic [W-1:0] m_frame = '0;

    logic s_sout, s_valid, s_start, s_done, s_ready;

    piso_serializer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .msb_first   (msb_first),
        .shift_en    (shift_en),
        .load_ready  (load_ready),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .frame_start (frame_start),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] tx_order(input logic [W-1:0] d, input logic m);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = m ? d[W-1-i] : d[i];
        return r;
    endfunction

    function automatic logic exp_ready();
        return !rst && (!m_active || (m_pos == W - 1 && shift_en));
    endfunction

    task automatic tick();
        logic e_sout, e_valid, e_start, e_done, e_ready, acc;
        @(negedge clk);
        e_valid = m_active;
        e_sout  = m_active ? m_frame[m_pos] : 1'b0;
        e_start = m_active && m_pos == 0;
        e_done  = m_active && m_pos == W - 1;
        e_ready = exp_ready();
        s_sout = sout; s_valid = sout_valid; s_start = frame_start; s_done = done; s_ready = load_ready;
        n_checks += 5;
        if (sout !== e_sout)         begin n_fail++; $display("FAIL sout t=%0t got=%b exp=%b", $time, sout, e_sout); end
        if (sout_valid !== e_valid)  begin n_fail++; $display("FAIL sout_valid t=%0t got=%b exp=%b", $time, sout_valid, e_valid); end
        if (frame_start !== e_start) begin n_fail++; $display("FAIL frame_start t=%0t got=%b exp=%b", $time, frame_start, e_start); end
        if (done !== e_done)         begin n_fail++; $display("FAIL done t=%0t got=%b exp=%b", $time, done, e_done); end
        if (load_ready !== e_ready)  begin n_fail++; $display("FAIL load_ready t=%0t got=%b exp=%b", $time, load_ready, e_ready); end
        @(posedge clk);
        if (!rst) begin
            acc = load_valid && exp_ready();
            if (m_active && shift_en) begin
                if (m_pos == W - 1) m_active = 1'b0;
                else m_pos++;
            end
            if (acc) begin
                m_frame  = tx_order(load_data, msb_first);
                m_pos    = 0;
                m_active = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drain();
        load_valid = 1'b0;
        shift_en   = 1'b1;
        for (int i = 0; i < W + 2; i++) tick();
    endtask

    task automatic test_reset();
        load_valid = 1'b1;
        load_data  = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 5;
        if (sout !== 1'b0)        begin n_fail++; $display("FAIL reset_sout got=%b exp=0", sout); end
        if (sout_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got=%b exp=0", sout_valid); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", frame_start); end
        if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        if (load_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready got=%b exp=0", load_ready); end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        rst        = 1'b0;
        tick();
        n_checks++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b exp=1", s_ready); end
    endtask

    task automatic run_frame(input logic [W-1:0] d, input logic m, output logic [W-1:0] bits,
                             output logic [W-1:0] starts, output logic [W-1:0] dones);
        load_valid = 1'b1; load_data = d; msb_first = m; shift_en = 1'b1;
        tick();
        load_valid = 1'b0; load_data = ~d; msb_first = ~m;
        for (int c = 0; c < W; c++) begin
            tick();
            bits[m ? W-1-c : c] = s_sout;
            starts[c] = s_start;
            dones[c]  = s_done;
        end
        tick();
        n_checks++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_frame got=%b exp=0", s_valid); end
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] b, s, dn;
        run_frame(8'hA5, 1'b0, b, s, dn);
        n_checks += 3;
        if (b !== 8'hA5)  begin n_fail++; $display("FAIL lsb_bits got=%h exp=a5", b); end
        if (s !== 8'h01)  begin n_fail++; $display("FAIL lsb_start got=%b exp=00000001", s); end
        if (dn !== 8'h80) begin n_fail++; $display("FAIL lsb_done got=%b exp=10000000", dn); end
    endtask

    task automatic test_msb_first();
        logic [W-1:0] b, s, dn;
        run_frame(8'hA5, 1'b1, b, s, dn);
        n_checks += 2;
        if (b !== 8'hA5)  begin n_fail++; $display("FAIL msb_bits got=%h exp=a5", b); end
        if (dn !== 8'h80) begin n_fail++; $display("FAIL msb_done got=%b exp=10000000", dn); end
        run_frame(8'h01, 1'b1, b, s, dn);
        n_checks += 2;
        if (b !== 8'h01)  begin n_fail++; $display("FAIL msb01_bits got=%h exp=01", b); end
        if (dn !== 8'h80) begin n_fail++; $display("FAIL msb01_done got=%b exp=10000000", dn); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits = '0;
        int nvalid = 0;
        logic [16:0] starts = '0;
        load_valid = 1'b1; load_data = 8'hFF; msb_first = 1'b0; shift_en = 1'b1;
        tick();
        load_data = 8'h00;
        for (int c = 1; c <= 17; c++) begin
            if (c == 9) load_valid = 1'b0;
            tick();
            if (s_valid) nvalid++;
            if (c <= 16) bits[c-1] = s_sout;
            starts[c-1] = s_start;
        end
        n_checks += 3;
        if (nvalid != 16)         begin n_fail++; $display("FAIL b2b_valid_count got=%0d exp=16", nvalid); end
        if (bits !== 16'h00FF)    begin n_fail++; $display("FAIL b2b_bits got=%h exp=00ff", bits); end
        if (starts !== 17'h00101) begin n_fail++; $display("FAIL b2b_starts got=%h exp=00101", starts); end
    endtask

    task automatic test_stall();
        logic [10:0] bits = '0;
        int done_at = 0;
        load_valid = 1'b1; load_data = 8'hC3; msb_first = 1'b0; shift_en = 1'b1;
        tick();
        load_valid = 1'b0; load_data = 8'h3C;
        for (int c = 1; c <= 12; c++) begin
            shift_en = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            tick();
            if (c <= 11) bits[c-1] = s_sout;
            if (s_done && done_at == 0) done_at = c;
        end
        n_checks += 2;
        if (bits !== 11'h61F) begin n_fail++; $display("FAIL stall_bits got=%h exp=61f", bits); end
        if (done_at != 11)    begin n_fail++; $display("FAIL stall_done_cycle got=%0d exp=11", done_at); end
    endtask

    task automatic test_mid_frame_load();
        logic [W-1:0] bits = '0;
        int rdy = 0;
        load_valid = 1'b1; load_data = 8'h5A; msb_first = 1'b1; shift_en = 1'b1;
        tick();
        for (int c = 1; c <= W; c++) begin
            load_valid = (c >= 2 && c <= 5);
            load_data  = W'($urandom);
            msb_first  = 1'($urandom);
            tick();
            bits[W-c] = s_sout;
            if (c >= 2 && c <= 5 && s_ready) rdy++;
        end
        load_valid = 1'b0;
        tick();
        n_checks += 3;
        if (bits !== 8'h5A) begin n_fail++; $display("FAIL midload_bits got=%h exp=5a", bits); end
        if (rdy != 0)       begin n_fail++; $display("FAIL midload_ready got=%0d exp=0", rdy); end
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL midload_idle got=%b exp=0", s_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] b, s, dn;
        load_valid = 1'b1; load_data = W'($urandom); msb_first = 1'($urandom); shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks += 5;
        if (sout !== 1'b0)        begin n_fail++; $display("FAIL rstmid_sout got=%b exp=0", sout); end
        if (sout_valid !== 1'b0)  begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", sout_valid); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_start got=%b exp=0", frame_start); end
        if (done !== 1'b0)        begin n_fail++; $display("FAIL rstmid_done got=%b exp=0", done); end
        if (load_ready !== 1'b0)  begin n_fail++; $display("FAIL rstmid_ready got=%b exp=0", load_ready); end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_active = 1'b0;
        m_pos    = 0;
        tick();
        run_frame(8'h3C, 1'b0, b, s, dn);
        n_checks += 2;
        if (b !== 8'h3C) begin n_fail++; $display("FAIL rstmid_fresh_bits got=%h exp=3c", b); end
        if (s !== 8'h01) begin n_fail++; $display("FAIL rstmid_fresh_start got=%b exp=00000001", s); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = W'($urandom);
            msb_first  = 1'($urandom);
            shift_en   = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_stall();
        test_mid_frame_load();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
